// File: rtl/parc_core_reorder_buffer_flush_pkg.sv
// Shared defaults for the pv2ooo reorder buffer.
// Depth, tag width and fill-port count used by the ROB and helpers.
package parc_core_reorder_buffer_flush_pkg;

  localparam int ROB_DEPTH  = 16;
  localparam int ROB_PTR_W  = 4;
  localparam int ROB_PREG_W = 5;
  localparam int ROB_NFILL  = 2;

endpackage

// File: rtl/parc_core_rob_age.sv
// Age of a ROB slot relative to the head index.
// Depth is a power of two, so the modulo is plain truncation.
module parc_core_rob_age
  import parc_core_reorder_buffer_flush_pkg::*;
#(
  parameter int PTR_W = ROB_PTR_W
)(
  input  logic [PTR_W-1:0] slot_i,
  input  logic [PTR_W-1:0] head_i,
  output logic [PTR_W-1:0] age_o
);

  assign age_o = slot_i - head_i;

endmodule

// File: rtl/parc_core_reorder_buffer_flush.sv
// In-order-commit reorder buffer with multi-port fill,
// commit backpressure and mispredict flush of younger entries.
module parc_core_reorder_buffer_flush
  import parc_core_reorder_buffer_flush_pkg::*;
#(
  parameter int DEPTH  = ROB_DEPTH,
  parameter int PTR_W  = ROB_PTR_W,
  parameter int PREG_W = ROB_PREG_W,
  parameter int NFILL  = ROB_NFILL
)(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rob_alloc_req_val,
  output logic                   rob_alloc_req_rdy,
  input  logic [PREG_W-1:0]      rob_alloc_req_preg,
  input  logic                   rob_alloc_req_wen,
  output logic [PTR_W-1:0]       rob_alloc_resp_slot,
  input  logic [NFILL-1:0]       rob_fill_val,
  input  logic [NFILL*PTR_W-1:0] rob_fill_slot,
  input  logic                   rob_flush_val,
  input  logic [PTR_W-1:0]       rob_flush_slot,
  output logic                   rob_commit_val,
  input  logic                   rob_commit_rdy,
  output logic                   rob_commit_wen,
  output logic [PTR_W-1:0]       rob_commit_slot,
  output logic [PREG_W-1:0]      rob_commit_rf_waddr,
  output logic [PTR_W:0]         rob_count
);

  localparam logic [PTR_W:0] PTR_ONE = (PTR_W+1)'(1);

  logic [PTR_W:0]               head_q, head_d;
  logic [PTR_W:0]               tail_q, tail_d;
  logic [DEPTH-1:0]             valid_q, valid_d;
  logic [DEPTH-1:0]             pend_q, pend_d;
  logic [DEPTH-1:0]             wen_q, wen_d;
  logic [DEPTH-1:0][PREG_W-1:0] preg_q, preg_d;

  logic [PTR_W-1:0] head_idx;
  logic [PTR_W-1:0] tail_idx;
  logic             full;
  logic             alloc_fire;
  logic             commit_fire;
  logic             flush_ok;
  logic [PTR_W-1:0] flush_age;
  logic [PTR_W-1:0] fill_slot [NFILL];
  logic [PTR_W-1:0] fill_age  [NFILL];
  logic [NFILL-1:0] fill_ok;
  logic [PTR_W-1:0] ent_age   [DEPTH];

  assign head_idx = head_q[PTR_W-1:0];
  assign tail_idx = tail_q[PTR_W-1:0];
  assign full     = (head_idx == tail_idx)
                  & (head_q[PTR_W] != tail_q[PTR_W]);

  assign rob_count           = tail_q - head_q;
  assign rob_alloc_req_rdy   = ~full & ~rob_flush_val;
  assign rob_alloc_resp_slot = tail_idx;
  assign rob_commit_val      = valid_q[head_idx] & ~pend_q[head_idx];
  assign rob_commit_wen      = rob_commit_val & wen_q[head_idx];
  assign rob_commit_slot     = head_idx;
  assign rob_commit_rf_waddr = preg_q[head_idx];

  assign alloc_fire  = rob_alloc_req_val & rob_alloc_req_rdy;
  assign commit_fire = rob_commit_val & rob_commit_rdy;

  parc_core_rob_age #(.PTR_W(PTR_W)) u_flush_age (
    .slot_i (rob_flush_slot),
    .head_i (head_idx),
    .age_o  (flush_age)
  );

  // Out-of-window flush slots are stale and must not shrink the ROB.
  assign flush_ok = rob_flush_val
                  & ({1'b0, flush_age} < rob_count);

  for (genvar k = 0; k < NFILL; k++) begin : g_fill
    assign fill_slot[k] = rob_fill_slot[k*PTR_W +: PTR_W];

    parc_core_rob_age #(.PTR_W(PTR_W)) u_fill_age (
      .slot_i (fill_slot[k]),
      .head_i (head_idx),
      .age_o  (fill_age[k])
    );

    assign fill_ok[k] = rob_fill_val[k]
                      & valid_q[fill_slot[k]]
                      & ({1'b0, fill_age[k]} < rob_count);
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_age
    localparam logic [PTR_W-1:0] IDX = PTR_W'(i);
    assign ent_age[i] = IDX - head_idx;
  end

  // Later updates override earlier ones: fill, commit, flush, alloc.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    valid_d = valid_q;
    pend_d  = pend_q;
    wen_d   = wen_q;
    preg_d  = preg_q;

    for (int k = 0; k < NFILL; k++) begin
      if (fill_ok[k]) pend_d[fill_slot[k]] = 1'b0;
    end

    if (commit_fire) begin
      valid_d[head_idx] = 1'b0;
      head_d            = head_q + PTR_ONE;
    end

    if (flush_ok) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_age[i] > flush_age) valid_d[i] = 1'b0;
      end
      tail_d = head_q + {1'b0, flush_age} + PTR_ONE;
    end

    if (alloc_fire) begin
      valid_d[tail_idx] = 1'b1;
      pend_d[tail_idx]  = 1'b1;
      wen_d[tail_idx]   = rob_alloc_req_wen;
      preg_d[tail_idx]  = rob_alloc_req_preg;
      tail_d            = tail_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= '0;
      pend_q  <= '0;
      wen_q   <= '0;
      preg_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      valid_q <= valid_d;
      pend_q  <= pend_d;
      wen_q   <= wen_d;
      preg_q  <= preg_d;
    end
  end

endmodule

// File: tb/tb_parc_core_reorder_buffer_flush.sv
// Directed and randomized bench for the reorder buffer,
// with an ordered-queue reference model of ROB contents.
module tb_parc_core_reorder_buffer_flush;

  localparam int DEPTH  = 16;
  localparam int PTR_W  = 4;
  localparam int PREG_W = 5;
  localparam int NFILL  = 2;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   alloc_val;
  logic                   alloc_rdy;
  logic [PREG_W-1:0]      alloc_preg;
  logic                   alloc_wen;
  logic [PTR_W-1:0]       resp_slot;
  logic [NFILL-1:0]       fill_val;
  logic [NFILL*PTR_W-1:0] fill_slot;
  logic                   flush_val;
  logic [PTR_W-1:0]       flush_slot;
  logic                   commit_val;
  logic                   commit_rdy;
  logic                   commit_wen;
  logic [PTR_W-1:0]       commit_slot;
  logic [PREG_W-1:0]      waddr;
  logic [PTR_W:0]         count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int slot;
    int preg;
    bit wen;
    bit filled;
  } ent_t;

  ent_t mq[$];
  int   mhead = 0;

  always #5 clk = ~clk;

  parc_core_reorder_buffer_flush #(
    .DEPTH(DEPTH), .PTR_W(PTR_W), .PREG_W(PREG_W), .NFILL(NFILL)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .rob_alloc_req_val   (alloc_val),
    .rob_alloc_req_rdy   (alloc_rdy),
    .rob_alloc_req_preg  (alloc_preg),
    .rob_alloc_req_wen   (alloc_wen),
    .rob_alloc_resp_slot (resp_slot),
    .rob_fill_val        (fill_val),
    .rob_fill_slot       (fill_slot),
    .rob_flush_val       (flush_val),
    .rob_flush_slot      (flush_slot),
    .rob_commit_val      (commit_val),
    .rob_commit_rdy      (commit_rdy),
    .rob_commit_wen      (commit_wen),
    .rob_commit_slot     (commit_slot),
    .rob_commit_rf_waddr (waddr),
    .rob_count           (count)
  );

  // Reference model: the ROB is an ordered list of in-flight entries.
  task automatic model_clk();
    int sz, a, tslot;
    bit cfire, afire;
    ent_t e;
    if (!reset) begin
      mq.delete();
      mhead = 0;
      return;
    end
    sz    = mq.size();
    cfire = (sz > 0) && mq[0].filled && commit_rdy;
    afire = alloc_val && (sz < DEPTH) && !flush_val;
    tslot = (mhead + sz) % DEPTH;
    for (int k = 0; k < NFILL; k++) begin
      if (fill_val[k]) begin
        a = (int'(fill_slot[k*PTR_W +: PTR_W]) - mhead + DEPTH) % DEPTH;
        if (a < sz) begin
          e = mq[a];
          e.filled = 1'b1;
          mq[a] = e;
        end
      end
    end
    if (flush_val) begin
      a = (int'(flush_slot) - mhead + DEPTH) % DEPTH;
      if (a < sz) while (mq.size() > a + 1) void'(mq.pop_back());
    end
    if (cfire) begin
      void'(mq.pop_front());
      mhead = (mhead + 1) % DEPTH;
    end
    if (afire) begin
      e.slot   = tslot;
      e.preg   = int'(alloc_preg);
      e.wen    = alloc_wen;
      e.filled = 1'b0;
      mq.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_clk();
    #1;
  endtask

  task automatic idle();
    alloc_val  = 1'b0;
    alloc_preg = '0;
    alloc_wen  = 1'b0;
    fill_val   = '0;
    fill_slot  = '0;
    flush_val  = 1'b0;
    flush_slot = '0;
  endtask

  task automatic set_fill(input int port, input int slot);
    fill_val[port] = 1'b1;
    fill_slot[port*PTR_W +: PTR_W] = PTR_W'(slot);
  endtask

  task automatic do_reset();
    idle();
    commit_rdy = 1'b0;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic alloc_n(input int n, input int preg0);
    for (int i = 0; i < n; i++) begin
      alloc_val  = 1'b1;
      alloc_preg = PREG_W'(preg0 + i);
      alloc_wen  = 1'b1;
      tick();
    end
    alloc_val = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (count !== 5'd0) begin
      errors++; $display("FAIL rst_count: got %0d want 0", count);
    end
    checks++;
    if (commit_val !== 1'b0 || commit_wen !== 1'b0) begin
      errors++; $display("FAIL rst_commit: got val=%b wen=%b want 0 0", commit_val, commit_wen);
    end
    checks++;
    if (commit_slot !== 4'd0 || waddr !== 5'd0) begin
      errors++; $display("FAIL rst_head: got slot=%0d waddr=%0d want 0 0", commit_slot, waddr);
    end
    checks++;
    if (alloc_rdy !== 1'b1 || resp_slot !== 4'd0) begin
      errors++; $display("FAIL rst_alloc: got rdy=%b slot=%0d want 1 0", alloc_rdy, resp_slot);
    end
  endtask

  task automatic test_inorder();
    for (int i = 0; i < 3; i++) begin
      alloc_val  = 1'b1;
      alloc_preg = PREG_W'(5 + i);
      alloc_wen  = 1'b1;
      #1;
      checks++;
      if (resp_slot !== PTR_W'(i) || alloc_rdy !== 1'b1) begin
        errors++; $display("FAIL io_resp%0d: got slot=%0d rdy=%b want %0d 1", i, resp_slot, alloc_rdy, i);
      end
      tick();
    end
    idle();
    checks++;
    if (count !== 5'd3 || commit_val !== 1'b0) begin
      errors++; $display("FAIL io_count: got count=%0d cval=%b want 3 0", count, commit_val);
    end
    set_fill(0, 1);
    tick();
    idle();
    checks++;
    if (commit_val !== 1'b0) begin
      errors++; $display("FAIL io_wait_head: got cval=%b want 0", commit_val);
    end
    set_fill(1, 0);
    tick();
    idle();
    checks++;
    if (commit_val !== 1'b1 || commit_slot !== 4'd0 || waddr !== 5'd5) begin
      errors++; $display("FAIL io_c0: got val=%b slot=%0d waddr=%0d want 1 0 5", commit_val, commit_slot, waddr);
    end
    commit_rdy = 1'b1;
    tick();
    checks++;
    if (commit_val !== 1'b1 || commit_slot !== 4'd1 || waddr !== 5'd6) begin
      errors++; $display("FAIL io_c1: got val=%b slot=%0d waddr=%0d want 1 1 6", commit_val, commit_slot, waddr);
    end
    tick();
    tick();
    checks++;
    if (commit_val !== 1'b0 || commit_slot !== 4'd2 || count !== 5'd1) begin
      errors++; $display("FAIL io_hold2: got val=%b slot=%0d count=%0d want 0 2 1", commit_val, commit_slot, count);
    end
    set_fill(0, 2);
    tick();
    idle();
    checks++;
    if (commit_val !== 1'b1 || waddr !== 5'd7) begin
      errors++; $display("FAIL io_c2: got val=%b waddr=%0d want 1 7", commit_val, waddr);
    end
    tick();
    commit_rdy = 1'b0;
    checks++;
    if (count !== 5'd0) begin
      errors++; $display("FAIL io_drain: got count=%0d want 0", count);
    end
  endtask

  task automatic test_full_wrap();
    do_reset();
    alloc_n(16, 0);
    checks++;
    if (alloc_rdy !== 1'b0 || count !== 5'd16 || resp_slot !== 4'd0) begin
      errors++; $display("FAIL fw_full: got rdy=%b count=%0d tail=%0d want 0 16 0", alloc_rdy, count, resp_slot);
    end
    for (int i = 0; i < 8; i++) begin
      set_fill(0, 2*i);
      set_fill(1, 2*i + 1);
      tick();
    end
    idle();
    alloc_val  = 1'b1;
    alloc_preg = 5'd31;
    commit_rdy = 1'b1;
    #1;
    checks++;
    if (alloc_rdy !== 1'b0) begin
      errors++; $display("FAIL fw_refuse: got rdy=%b want 0", alloc_rdy);
    end
    tick();
    alloc_val = 1'b0;
    checks++;
    if (count !== 5'd15 || alloc_rdy !== 1'b1 || commit_slot !== 4'd1) begin
      errors++; $display("FAIL fw_one: got count=%0d rdy=%b head=%0d want 15 1 1", count, alloc_rdy, commit_slot);
    end
    for (int i = 0; i < 15; i++) tick();
    commit_rdy = 1'b0;
    checks++;
    if (count !== 5'd0 || commit_slot !== 4'd0 || resp_slot !== 4'd0 || commit_val !== 1'b0) begin
      errors++; $display("FAIL fw_wrap: got count=%0d head=%0d tail=%0d cval=%b want 0 0 0 0", count, commit_slot, resp_slot, commit_val);
    end
    alloc_n(1, 4);
    checks++;
    if (count !== 5'd1 || resp_slot !== 4'd1) begin
      errors++; $display("FAIL fw_post: got count=%0d tail=%0d want 1 1", count, resp_slot);
    end
  endtask

  task automatic test_flush();
    do_reset();
    alloc_n(14, 0);
    for (int i = 0; i < 7; i++) begin
      set_fill(0, 2*i);
      set_fill(1, 2*i + 1);
      tick();
    end
    idle();
    commit_rdy = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    commit_rdy = 1'b0;
    checks++;
    if (commit_slot !== 4'd14 || count !== 5'd0) begin
      errors++; $display("FAIL fl_head: got head=%0d count=%0d want 14 0", commit_slot, count);
    end
    alloc_n(5, 20);
    checks++;
    if (count !== 5'd5 || resp_slot !== 4'd3) begin
      errors++; $display("FAIL fl_five: got count=%0d tail=%0d want 5 3", count, resp_slot);
    end
    flush_val  = 1'b1;
    flush_slot = 4'd15;
    alloc_val  = 1'b1;
    set_fill(0, 1);
    #1;
    checks++;
    if (alloc_rdy !== 1'b0) begin
      errors++; $display("FAIL fl_block: got rdy=%b want 0", alloc_rdy);
    end
    tick();
    idle();
    checks++;
    if (count !== 5'd2 || resp_slot !== 4'd0) begin
      errors++; $display("FAIL fl_cut: got count=%0d tail=%0d want 2 0", count, resp_slot);
    end
    set_fill(1, 1);
    tick();
    idle();
    alloc_n(1, 30);
    checks++;
    if (count !== 5'd3 || resp_slot !== 4'd1) begin
      errors++; $display("FAIL fl_realloc: got count=%0d tail=%0d want 3 1", count, resp_slot);
    end
    set_fill(0, 14);
    set_fill(1, 15);
    tick();
    idle();
    commit_rdy = 1'b1;
    tick();
    checks++;
    if (commit_slot !== 4'd15 || commit_val !== 1'b1 || waddr !== 5'd21) begin
      errors++; $display("FAIL fl_c15: got head=%0d cval=%b waddr=%0d want 15 1 21", commit_slot, commit_val, waddr);
    end
    tick();
    commit_rdy = 1'b0;
    checks++;
    if (commit_slot !== 4'd0 || commit_val !== 1'b0 || count !== 5'd1) begin
      errors++; $display("FAIL fl_new0: got head=%0d cval=%b count=%0d want 0 0 1", commit_slot, commit_val, count);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    alloc_val  = 1'b1;
    alloc_preg = 5'd9;
    alloc_wen  = 1'b1;
    tick();
    alloc_preg = 5'd3;
    alloc_wen  = 1'b0;
    tick();
    idle();
    set_fill(0, 0);
    set_fill(1, 1);
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (commit_val !== 1'b1 || commit_slot !== 4'd0 || waddr !== 5'd9 || commit_wen !== 1'b1 || count !== 5'd2) begin
        errors++; $display("FAIL bp_hold%0d: got val=%b slot=%0d waddr=%0d wen=%b count=%0d want 1 0 9 1 2", i, commit_val, commit_slot, waddr, commit_wen, count);
      end
    end
    commit_rdy = 1'b1;
    tick();
    commit_rdy = 1'b0;
    checks++;
    if (count !== 5'd1 || commit_slot !== 4'd1 || commit_val !== 1'b1 || commit_wen !== 1'b0 || waddr !== 5'd3) begin
      errors++; $display("FAIL bp_one: got count=%0d slot=%0d val=%b wen=%b waddr=%0d want 1 1 1 0 3", count, commit_slot, commit_val, commit_wen, waddr);
    end
    tick();
    checks++;
    if (count !== 5'd1) begin
      errors++; $display("FAIL bp_stop: got count=%0d want 1", count);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    alloc_n(4, 10);
    set_fill(0, 0);
    set_fill(1, 1);
    tick();
    idle();
    checks++;
    if (count !== 5'd4 || commit_val !== 1'b1) begin
      errors++; $display("FAIL rm_pre: got count=%0d cval=%b want 4 1", count, commit_val);
    end
    reset      = 1'b0;
    commit_rdy = 1'b1;
    set_fill(0, 2);
    tick();
    reset = 1'b1;
    checks++;
    if (count !== 5'd0 || commit_val !== 1'b0 || alloc_rdy !== 1'b1) begin
      errors++; $display("FAIL rm_post: got count=%0d cval=%b rdy=%b want 0 0 1", count, commit_val, alloc_rdy);
    end
    set_fill(0, 0);
    set_fill(1, 1);
    tick();
    idle();
    commit_rdy = 1'b0;
    checks++;
    if (count !== 5'd0 || commit_val !== 1'b0) begin
      errors++; $display("FAIL rm_stale: got count=%0d cval=%b want 0 0", count, commit_val);
    end
  endtask

  task automatic test_random();
    int sz;
    bit ecv;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      alloc_val  = ($urandom_range(0, 9) < 6);
      alloc_preg = PREG_W'($urandom);
      alloc_wen  = 1'($urandom);
      fill_val   = NFILL'($urandom);
      fill_slot  = (NFILL*PTR_W)'($urandom);
      flush_val  = ($urandom_range(0, 19) == 0);
      flush_slot = PTR_W'($urandom);
      commit_rdy = ($urandom_range(0, 9) < 7);
      #1;
      sz = mq.size();
      checks++;
      if (alloc_rdy !== ((sz < DEPTH) && !flush_val) || int'(resp_slot) != (mhead + sz) % DEPTH) begin
        errors++; $display("FAIL rnd_alloc@%0d: got rdy=%b slot=%0d want size=%0d head=%0d", n, alloc_rdy, resp_slot, sz, mhead);
      end
      tick();
      sz  = mq.size();
      ecv = (sz > 0) && mq[0].filled;
      checks++;
      if (int'(count) != sz || commit_val !== ecv || int'(commit_slot) != mhead) begin
        errors++; $display("FAIL rnd_state@%0d: got count=%0d cval=%b head=%0d want %0d %b %0d", n, count, commit_val, commit_slot, sz, ecv, mhead);
      end
      if (ecv) begin
        checks++;
        if (int'(waddr) != mq[0].preg || commit_wen !== mq[0].wen) begin
          errors++; $display("FAIL rnd_head@%0d: got waddr=%0d wen=%b want %0d %b", n, waddr, commit_wen, mq[0].preg, mq[0].wen);
        end
      end
    end
    idle();
    commit_rdy = 1'b0;
  endtask

  initial begin
    idle();
    commit_rdy = 1'b0;
    reset      = 1'b0;
    test_reset();
    test_inorder();
    test_full_wrap();
    test_flush();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
